// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
// axis_beat_t is the stored beat layout at the default data width.
package axis_pkg;

    localparam int AXIS_DATA_W = 8;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

    // One extra MSB beyond the address bits lets full and empty be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Register-array storage for the stream FIFO.
// It has a synchronous write port and an asynchronous read port for first-word fall-through.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with cut-through or store-and-forward packet mode.
// It reports beat occupancy and the number of complete packets held.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int PKT_MODE = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   pkt_count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [PTR_W-1:0] occupancy;
    logic             wr_en, rd_en;
    beat_t            wr_beat, head_beat;

    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign full          = (occupancy == DEPTH_P);
    assign empty         = (occupancy == '0);
    assign count         = occupancy;
    assign pkt_count     = pkt_cnt_q;
    assign s_axis_tready = rst & ~full;

    assign wr_beat       = '{last: s_axis_tlast, data: s_axis_tdata};
    assign m_axis_tdata  = head_beat.data;
    assign m_axis_tlast  = head_beat.last;

    assign wr_en = s_axis_tvalid & s_axis_tready;
    assign rd_en = m_axis_tvalid & m_axis_tready;

    // Packet mode waits for a whole packet; a full FIFO releases data so oversize packets cannot deadlock.
    always_comb begin
        m_axis_tvalid = 1'b0;
        if (PKT_MODE == 0) begin
            m_axis_tvalid = ~empty;
        end else begin
            m_axis_tvalid = ~empty & ((pkt_cnt_q != '0) | full);
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en & s_axis_tlast, rd_en & m_axis_tlast})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    axis_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (head_beat)
    );

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: three configurations run against a queue-based model.
// Directed sequences also pin the model with hand-computed literal expectations.
module tb_axis_pkt_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Index 0: DEPTH 16 cut-through, 1: DEPTH 16 packet mode, 2: DEPTH 4 packet mode
    logic [7:0] sData  [3];
    logic       sValid [3];
    logic       sLast  [3];
    logic       sReady [3];
    logic [7:0] mData  [3];
    logic       mValid [3];
    logic       mLast  [3];
    logic       mReady [3];
    logic [4:0] cnt    [3];
    logic [4:0] pkt    [3];
    logic       fullS  [3];
    logic       emptyS [3];
    logic [2:0] cnt2, pkt2;

    assign cnt[2] = {2'b00, cnt2};
    assign pkt[2] = {2'b00, pkt2};

    axis_pkt_fifo #(.DATA_W(8), .DEPTH(16), .PKT_MODE(0)) dutCut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(sData[0]), .s_axis_tvalid(sValid[0]), .s_axis_tlast(sLast[0]), .s_axis_tready(sReady[0]),
        .m_axis_tdata(mData[0]), .m_axis_tvalid(mValid[0]), .m_axis_tlast(mLast[0]), .m_axis_tready(mReady[0]),
        .count(cnt[0]), .pkt_count(pkt[0]), .full(fullS[0]), .empty(emptyS[0])
    );

    axis_pkt_fifo #(.DATA_W(8), .DEPTH(16), .PKT_MODE(1)) dutPkt (
        .clk(clk), .rst(rst),
        .s_axis_tdata(sData[1]), .s_axis_tvalid(sValid[1]), .s_axis_tlast(sLast[1]), .s_axis_tready(sReady[1]),
        .m_axis_tdata(mData[1]), .m_axis_tvalid(mValid[1]), .m_axis_tlast(mLast[1]), .m_axis_tready(mReady[1]),
        .count(cnt[1]), .pkt_count(pkt[1]), .full(fullS[1]), .empty(emptyS[1])
    );

    axis_pkt_fifo #(.DATA_W(8), .DEPTH(4), .PKT_MODE(1)) dutSmall (
        .clk(clk), .rst(rst),
        .s_axis_tdata(sData[2]), .s_axis_tvalid(sValid[2]), .s_axis_tlast(sLast[2]), .s_axis_tready(sReady[2]),
        .m_axis_tdata(mData[2]), .m_axis_tvalid(mValid[2]), .m_axis_tlast(mLast[2]), .m_axis_tready(mReady[2]),
        .count(cnt2), .pkt_count(pkt2), .full(fullS[2]), .empty(emptyS[2])
    );

    // Model: each FIFO is an ordered list of {last, data} beats held in a ring.
    logic [8:0] store [3][32];
    int         head  [3];
    int         size  [3];

    function automatic int depthOf(input int k);
        return (k == 2) ? 4 : 16;
    endfunction

    function automatic int modeOf(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int pktOf(input int k);
        int n = 0;
        for (int i = 0; i < size[k]; i++) begin
            if (store[k][(head[k] + i) % 32][8]) n++;
        end
        return n;
    endfunction

    function automatic bit expValid(input int k);
        return (size[k] > 0) && (modeOf(k) == 0 || pktOf(k) > 0 || size[k] == depthOf(k));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on instance k, then step to just after the next rising edge.
    task automatic applyStimulus(input int k, input logic v, input logic [7:0] d, input logic l, input logic r);
        sValid[k] = v;
        sData[k]  = d;
        sLast[k]  = l;
        mReady[k] = r;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                head[k] = 0;
                size[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit wr;
                bit rd;
                wr = sValid[k] && (size[k] != depthOf(k));
                rd = expValid(k) && mReady[k];
                if (rd) begin
                    head[k] = (head[k] + 1) % 32;
                    size[k] = size[k] - 1;
                end
                if (wr) begin
                    store[k][(head[k] + size[k]) % 32] = {sLast[k], sData[k]};
                    size[k] = size[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("model.count%0d", k), int'(cnt[k]), size[k]);
            checkOutput($sformatf("model.pkt%0d", k), int'(pkt[k]), pktOf(k));
            checkOutput($sformatf("model.full%0d", k), int'(fullS[k]), int'(size[k] == depthOf(k)));
            checkOutput($sformatf("model.empty%0d", k), int'(emptyS[k]), int'(size[k] == 0));
            checkOutput($sformatf("model.sReady%0d", k), int'(sReady[k]), int'(rst && size[k] != depthOf(k)));
            checkOutput($sformatf("model.mValid%0d", k), int'(mValid[k]), int'(expValid(k)));
            if (expValid(k)) begin
                checkOutput($sformatf("model.mData%0d", k), int'(mData[k]), int'(store[k][head[k]][7:0]));
                checkOutput($sformatf("model.mLast%0d", k), int'(mLast[k]), int'(store[k][head[k]][8]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        int got;
        int firstReadAt;
        bit sawFull;
        bit acc;
        bit del;
        logic [7:0] rx [6];
        logic       rxLast [6];
        logic [7:0] hist [128];
        logic [7:0] d;

        for (int k = 0; k < 3; k++) begin
            sValid[k] = 1'b0;
            sData[k]  = 8'h00;
            sLast[k]  = 1'b0;
            mReady[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstCount", int'(cnt[0]), 0);
        checkOutput("rstEmpty", int'(emptyS[0]), 1);
        checkOutput("rstFull", int'(fullS[0]), 0);
        checkOutput("rstSReady", int'(sReady[0]), 0);
        checkOutput("rstMValid", int'(mValid[0]), 0);
        rst = 1'b1;
        #1;
        checkOutput("relSReady", int'(sReady[0]), 1);

        // Single beat, cut-through
        applyStimulus(0, 1'b1, 8'h05, 1'b1, 1'b0);
        sValid[0] = 1'b0;
        checkOutput("oneMValid", int'(mValid[0]), 1);
        checkOutput("oneMData", int'(mData[0]), 8'h05);
        checkOutput("oneMLast", int'(mLast[0]), 1);
        checkOutput("oneCount", int'(cnt[0]), 1);
        checkOutput("onePkt", int'(pkt[0]), 1);
        applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
        mReady[0] = 1'b0;
        checkOutput("oneDrained", int'(emptyS[0]), 1);
        checkOutput("onePktZero", int'(pkt[0]), 0);

        // Fill to 16, hold a 17th beat, then drain in order
        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("fillFull", int'(fullS[0]), 1);
        checkOutput("fillSReady", int'(sReady[0]), 0);
        checkOutput("fillCount", int'(cnt[0]), 16);
        applyStimulus(0, 1'b1, 8'hEE, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("heldCount", int'(cnt[0]), 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drainValid", int'(mValid[0]), 1);
            checkOutput("drainData", int'(mData[0]), i);
            applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        mReady[0] = 1'b0;
        checkOutput("drainEmpty", int'(emptyS[0]), 1);

        // Packet mode: output held until tlast is stored
        applyStimulus(1, 1'b1, 8'hA1, 1'b0, 1'b1);
        checkOutput("pktHold1", int'(mValid[1]), 0);
        applyStimulus(1, 1'b1, 8'hA2, 1'b0, 1'b1);
        checkOutput("pktHold2", int'(mValid[1]), 0);
        applyStimulus(1, 1'b1, 8'hA3, 1'b1, 1'b1);
        checkOutput("pktRelease", int'(mValid[1]), 1);
        checkOutput("pktCount1", int'(pkt[1]), 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("pktOutValid", int'(mValid[1]), 1);
            checkOutput("pktOutData", int'(mData[1]), 8'hA1 + i);
            checkOutput("pktOutLast", int'(mLast[1]), int'(i == 2));
            applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        mReady[1] = 1'b0;
        checkOutput("pktCount0", int'(pkt[1]), 0);
        checkOutput("pktEmpty", int'(emptyS[1]), 1);

        // Oversize packet in a 4-deep packet-mode FIFO
        sent = 0;
        got = 0;
        firstReadAt = -1;
        sawFull = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            sValid[2] = (sent < 6);
            sData[2]  = 8'(8'hB0 + sent);
            sLast[2]  = (sent == 5);
            mReady[2] = 1'b1;
            acc = sValid[2] && sReady[2];
            del = mValid[2] && mReady[2];
            if (del) begin
                rx[got]     = mData[2];
                rxLast[got] = mLast[2];
                if (firstReadAt < 0) firstReadAt = sent;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (del) got++;
            if (fullS[2]) sawFull = 1'b1;
        end
        sValid[2] = 1'b0;
        mReady[2] = 1'b0;
        checkOutput("bigSawFull", int'(sawFull), 1);
        checkOutput("bigFirstReadAfter", firstReadAt, 4);
        checkOutput("bigDelivered", got, 6);
        for (int i = 0; i < got; i++) begin
            checkOutput("bigData", int'(rx[i]), 8'hB0 + i);
            checkOutput("bigLast", int'(rxLast[i]), int'(i == 5));
        end
        checkOutput("bigEmpty", int'(emptyS[2]), 1);

        // Continuous streaming at occupancy 5
        for (int i = 0; i < 5; i++) begin
            hist[i] = 8'(8'h50 + i);
            applyStimulus(0, 1'b1, hist[i], 1'b0, 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom);
            hist[i + 5] = d;
            checkOutput("streamCount", int'(cnt[0]), 5);
            checkOutput("streamData", int'(mData[0]), int'(hist[i]));
            applyStimulus(0, 1'b1, d, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
        mReady[0] = 1'b0;
        checkOutput("streamEmpty", int'(emptyS[0]), 1);

        // Reset in the middle of a packet
        for (int i = 0; i < 7; i++) applyStimulus(0, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        sValid[0] = 1'b0;
        checkOutput("midCount7", int'(cnt[0]), 7);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRstCount", int'(cnt[0]), 0);
        checkOutput("midRstMValid", int'(mValid[0]), 0);
        checkOutput("midRstSReady", int'(sReady[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRelSReady", int'(sReady[0]), 1);
        applyStimulus(0, 1'b1, 8'hC1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 8'hC2, 1'b1, 1'b0);
        sValid[0] = 1'b0;
        checkOutput("newCount", int'(cnt[0]), 2);
        checkOutput("newData1", int'(mData[0]), 8'hC1);
        applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("newData2", int'(mData[0]), 8'hC2);
        checkOutput("newLast2", int'(mLast[0]), 1);
        applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
        mReady[0] = 1'b0;
        checkOutput("newEmpty", int'(emptyS[0]), 1);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
